// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding
// and the round-robin index wrap used by both the picker and the release path.
package uart_tx_arbiter_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND    = 3'd1,
      ST_WAIT_HI = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_NEXT    = 3'd4
   } state_e;

   // Index following idx in a ring of n entries (n-1 wraps to 0).
   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i,
// scanning upwards and wrapping from NUM_REQ-1 back to 0.
module uart_tx_arbiter_rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    rr_ptr_i,
   output logic               any_valid_o,
   output logic [ID_W-1:0]    winner_o
);

   int   idx;
   logic cand;

   always_comb begin
      any_valid_o = 1'b0;
      winner_o    = '0;
      idx         = int'(rr_ptr_i);
      cand        = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = 1'b0;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (j == idx) cand = req_i[j];
         end
         if (!any_valid_o && cand) begin
            any_valid_o = 1'b1;
            winner_o    = ID_W'(idx);
         end
         idx = next_idx(idx, NUM_REQ);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters with
// round-robin arbitration; the winner keeps the UART until its last byte is sent.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 2,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [8*NUM_REQ-1:0]  req_data,
   input  logic [NUM_REQ-1:0]    req_last,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [7:0]            uart_tx_data,
   output logic                  uart_tx_send,
   input  logic                  uart_tx_busy,
   output logic                  grant_active,
   output logic [ID_W-1:0]       grant_id,
   output logic                  err_timeout
);

   localparam int               CNT_W    = $clog2(BUSY_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   state_e                state_q;
   logic [ID_W-1:0]       rr_ptr_q;
   logic [ID_W-1:0]       grant_id_q;
   logic [BYTE_W-1:0]     data_q;
   logic                  last_q;
   logic                  send_q;
   logic                  active_q;
   logic                  err_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  any_valid;
   logic [ID_W-1:0]       winner;
   logic [ID_W-1:0]       sel_id;
   logic [BYTE_W-1:0]     sel_data;
   logic                  sel_last;
   logic                  sel_valid;
   logic                  take;

   uart_tx_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req_i       (req_valid),
      .rr_ptr_i    (rr_ptr_q),
      .any_valid_o (any_valid),
      .winner_o    (winner)
   );

   // The candidate requester is the RR winner when free, else the lock owner.
   assign sel_id = (state_q == ST_IDLE) ? winner : grant_id_q;

   always_comb begin
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (ID_W'(j) == sel_id) begin
            sel_data  = req_data[j*BYTE_W +: BYTE_W];
            sel_last  = req_last[j];
            sel_valid = req_valid[j];
         end
      end
   end

   assign take = ((state_q == ST_IDLE) && any_valid && !uart_tx_busy) ||
                 ((state_q == ST_NEXT) && sel_valid);

   always_comb begin
      req_ready = '0;
      if (take) req_ready = NUM_REQ'(1) << sel_id;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         data_q     <= '0;
         last_q     <= 1'b0;
         send_q     <= 1'b0;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         send_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE, ST_NEXT: begin
               if (take) begin
                  data_q     <= sel_data;
                  last_q     <= sel_last;
                  grant_id_q <= sel_id;
                  active_q   <= 1'b1;
                  send_q     <= 1'b1;
                  state_q    <= ST_SEND;
               end
            end
            ST_SEND: begin
               cnt_q   <= '0;
               state_q <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (uart_tx_busy) begin
                  state_q <= ST_WAIT_LO;
               end else if (cnt_q == CNT_LAST) begin
                  // UART never acknowledged: drop the frame and move the RR pointer on.
                  err_q    <= 1'b1;
                  active_q <= 1'b0;
                  rr_ptr_q <= ID_W'(next_idx(int'(grant_id_q), NUM_REQ));
                  state_q  <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WAIT_LO: begin
               if (!uart_tx_busy) begin
                  if (last_q) begin
                     active_q <= 1'b0;
                     rr_ptr_q <= ID_W'(next_idx(int'(grant_id_q), NUM_REQ));
                     state_q  <= ST_IDLE;
                  end else begin
                     state_q  <= ST_NEXT;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign uart_tx_data = data_q;
   assign uart_tx_send = send_q;
   assign grant_active = active_q;
   assign grant_id     = grant_id_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: timestamp-based reference model of
// grant/send/release rules, directed scenarios with literal checks, then random traffic.
module tb_uart_tx_arbiter;

   localparam int N        = 4;
   localparam int IDW      = 2;
   localparam int TO       = 8;
   localparam int BUSY_LEN = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [8*N-1:0]   req_data;
   logic [N-1:0]     req_last;
   logic [N-1:0]     req_ready;
   logic [7:0]       uart_tx_data;
   logic             uart_tx_send;
   logic             uart_tx_busy;
   logic             grant_active;
   logic [IDW-1:0]   grant_id;
   logic             err_timeout;

   uart_tx_arbiter #(.NUM_REQ(N), .ID_W(IDW), .BUSY_TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .uart_tx_data (uart_tx_data),
      .uart_tx_send (uart_tx_send),
      .uart_tx_busy (uart_tx_busy),
      .grant_active (grant_active),
      .grant_id     (grant_id),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // UART model state
   int ub_cnt     = 0;
   bit uart_dead  = 1'b0;
   bit force_busy = 1'b0;

   // Samples taken at the falling edge
   logic [N-1:0]   s_ready, s_acc;
   logic           s_send, s_err, s_active;
   logic [7:0]     s_data;
   logic [IDW-1:0] s_gid;
   byte unsigned   uart_q[$];
   int             grants_q[$];
   int             err_q[$];
   int             n_send = 0;

   // Reference model: owner/rr plus timestamps of the byte in flight
   bit         m_known    = 1'b0;
   int         m_owner    = -1;
   int         m_gid      = 0;
   int         m_rr       = 0;
   bit         m_inflight = 1'b0;
   bit         m_hi       = 1'b0;
   bit         m_last     = 1'b0;
   logic [7:0] m_data     = 8'h00;
   int         m_acc      = 0;
   int         m_err_cyc  = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r;
      bit           found;
      r     = '0;
      found = 1'b0;
      if (m_owner < 0) begin
         if (!uart_tx_busy) begin
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_rr + k) % N;
               if (!found && req_valid[j]) begin
                  r[j]  = 1'b1;
                  found = 1'b1;
               end
            end
         end
      end else if (!m_inflight) begin
         r[m_owner] = req_valid[m_owner];
      end
      return r;
   endfunction

   task automatic model_advance(input logic [N-1:0] er);
      logic [N-1:0] acc;
      acc = er & req_valid;
      if (rst) begin
         m_known = 1'b1; m_owner = -1; m_gid = 0; m_rr = 0; m_inflight = 1'b0;
         m_hi = 1'b0; m_last = 1'b0; m_data = 8'h00; m_err_cyc = -1;
         return;
      end
      if (acc != '0) begin
         for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
               m_owner = k; m_gid = k; m_data = req_data[8*k +: 8]; m_last = req_last[k];
            end
         end
         m_inflight = 1'b1; m_hi = 1'b0; m_acc = cyc;
      end else if (m_inflight) begin
         if (!m_hi) begin
            // busy is watched from two cycles after acceptance, for TO cycles
            if (cyc >= m_acc + 2) begin
               if (uart_tx_busy) m_hi = 1'b1;
               else if (cyc == m_acc + 1 + TO) begin
                  m_err_cyc = cyc + 1; m_rr = (m_owner + 1) % N; m_owner = -1; m_inflight = 1'b0;
               end
            end
         end else if (!uart_tx_busy) begin
            m_inflight = 1'b0;
            if (m_last) begin
               m_rr = (m_owner + 1) % N; m_owner = -1;
            end
         end
      end
   endtask

   task automatic tick();
      logic [N-1:0] er;
      @(negedge clk);
      s_ready  = req_ready;
      s_send   = uart_tx_send;
      s_data   = uart_tx_data;
      s_active = grant_active;
      s_gid    = grant_id;
      s_err    = err_timeout;
      s_acc    = req_ready & req_valid;
      if (s_send === 1'b1) begin uart_q.push_back(uart_tx_data); n_send++; end
      if (s_err === 1'b1) err_q.push_back(cyc);
      for (int k = 0; k < N; k++) if (s_acc[k] === 1'b1 && !rst) grants_q.push_back(k);
      er = model_ready();
      if (m_known) begin
         chk("ready",  32'(s_ready),  32'(er));
         chk("send",   32'(s_send),   32'(m_inflight && cyc == m_acc + 1));
         chk("data",   32'(s_data),   32'(m_data));
         chk("active", 32'(s_active), 32'(m_owner >= 0));
         chk("gid",    32'(s_gid),    32'(m_gid));
         chk("err",    32'(s_err),    32'(cyc == m_err_cyc));
      end
      model_advance(er);
      @(posedge clk);
      #1;
      cyc++;
      if (s_send === 1'b1 && !uart_dead) ub_cnt = BUSY_LEN;
      else if (ub_cnt > 0) ub_cnt--;
      uart_tx_busy = (ub_cnt > 0) || force_busy;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [7:0] d, input logic l);
      req_data[8*i +: 8] = d;
      req_last[i]        = l;
      req_valid[i]       = 1'b1;
   endtask

   task automatic wait_acc(input int i, input string name);
      int n;
      n = 0;
      do begin tick(); n++; end while (s_acc[i] !== 1'b1 && n < 200);
      chk(name, 32'(s_acc[i]), 32'd1);
   endtask

   task automatic drain();
      int n;
      req_valid = '0;
      n = 0;
      do begin tick(); n++; end while ((s_active !== 1'b0 || ub_cnt != 0) && n < 200);
      chk("drain", 32'(s_active), 32'd0);
   endtask

   byte unsigned t3_b[3] = '{8'h11, 8'h22, 8'h33};
   bit           t3_l[3] = '{1'b0, 1'b0, 1'b1};

   initial begin
      int a, p, n, n0, g3, fb;
      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; uart_tx_busy = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state and single-byte frame from req0
      tick();
      chk("rst_ready",  32'(s_ready),  32'd0);
      chk("rst_active", 32'(s_active), 32'd0);
      chk("rst_send",   32'(s_send),   32'd0);
      chk("rst_data",   32'(s_data),   32'd0);
      chk("rst_err",    32'(s_err),    32'd0);
      chk("rst_gid",    32'(s_gid),    32'd0);
      set_req(0, 8'hA5, 1'b1);
      tick();
      chk("t1_ready", 32'(s_ready), 32'b0001);
      req_valid = '0;
      tick();
      chk("t1_send", 32'(s_send), 32'd1);
      chk("t1_data", 32'(s_data), 32'hA5);
      repeat (11) tick();
      chk("t1_hold", 32'(s_active), 32'd1);
      tick();
      chk("t1_release", 32'(s_active), 32'd0);
      drain();

      // Simultaneous req0/req2: order 0, 2, 0
      do_reset();
      grants_q.delete();
      set_req(0, 8'h01, 1'b1);
      set_req(2, 8'h02, 1'b1);
      n = 0;
      while (grants_q.size() < 3 && n < 300) begin
         tick(); n++;
         if (s_acc[2] === 1'b1) req_valid[2] = 1'b0;
      end
      chk("t2_count", 32'(grants_q.size()), 32'd3);
      if (grants_q.size() >= 3) begin
         chk("t2_g0", 32'(grants_q[0]), 32'd0);
         chk("t2_g1", 32'(grants_q[1]), 32'd2);
         chk("t2_g2", 32'(grants_q[2]), 32'd0);
      end
      drain();

      // Three-byte frame from req1 is not interleaved with req3
      do_reset();
      uart_q.delete();
      set_req(3, 8'h44, 1'b1);
      p = 0; n = 0;
      while (uart_q.size() < 4 && n < 300) begin
         if (p < 3) set_req(1, t3_b[p], t3_l[p]);
         tick(); n++;
         if (s_acc[1] === 1'b1) begin p++; if (p == 3) req_valid[1] = 1'b0; end
         if (s_acc[3] === 1'b1) req_valid[3] = 1'b0;
      end
      chk("t3_count", 32'(uart_q.size()), 32'd4);
      if (uart_q.size() >= 4) begin
         chk("t3_b0", 32'(uart_q[0]), 32'h11);
         chk("t3_b1", 32'(uart_q[1]), 32'h22);
         chk("t3_b2", 32'(uart_q[2]), 32'h33);
         chk("t3_b3", 32'(uart_q[3]), 32'h44);
      end
      drain();

      // Owner pauses mid-frame: lock holds, no sends, req3 starved
      do_reset();
      set_req(1, 8'h11, 1'b0);
      set_req(3, 8'h44, 1'b1);
      wait_acc(1, "t4_acc");
      req_valid[1] = 1'b0;
      n0 = n_send; g3 = 0;
      repeat (34) begin tick(); if (s_acc[3] === 1'b1) g3++; end
      chk("t4_sends",  32'(n_send - n0), 32'd1);
      chk("t4_req3",   32'(g3),          32'd0);
      chk("t4_active", 32'(s_active),    32'd1);
      chk("t4_gid",    32'(s_gid),       32'd1);
      set_req(1, 8'h55, 1'b1);
      wait_acc(1, "t4_acc2");
      req_valid[1] = 1'b0;
      wait_acc(3, "t4_acc3");
      drain();

      // UART never goes busy: timeout pulse, then RR resumes after the owner
      do_reset();
      uart_dead = 1'b1;
      err_q.delete();
      set_req(2, 8'h66, 1'b1);
      wait_acc(2, "t5_acc");
      a = cyc - 1;
      req_valid = '0;
      repeat (12) tick();
      chk("t5_errs", 32'(err_q.size()), 32'd1);
      if (err_q.size() == 1) chk("t5_err_at", 32'(err_q[0] - a), 32'd10);
      chk("t5_active", 32'(s_active), 32'd0);
      uart_dead = 1'b0;
      grants_q.delete();
      set_req(0, 8'h0A, 1'b1);
      set_req(3, 8'h3A, 1'b1);
      n = 0;
      do begin tick(); n++; end while (s_acc === '0 && n < 100);
      chk("t5_next_grant", 32'(s_acc), 32'b1000);
      drain();

      // Reset while waiting for busy to fall, then normal service
      do_reset();
      set_req(2, 8'h70, 1'b1);
      wait_acc(2, "t6_acc");
      req_valid = '0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(2, 8'h77, 1'b1);
      tick();
      chk("t6_active", 32'(s_active), 32'd0);
      chk("t6_send",   32'(s_send),   32'd0);
      chk("t6_data",   32'(s_data),   32'd0);
      chk("t6_gid",    32'(s_gid),    32'd0);
      chk("t6_ready",  32'(s_ready),  32'd0);
      n = 0;
      do begin
         tick(); n++;
         if (s_acc[2] === 1'b1) req_valid[2] = 1'b0;
      end while (s_send !== 1'b1 && n < 100);
      chk("t6_send2", 32'(s_send), 32'd1);
      chk("t6_byte",  32'(s_data), 32'h77);
      drain();

      // Random traffic against the model
      do_reset();
      fb = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < N; k++) begin
            req_valid[k] = ($urandom_range(0, 9) < 7);
            req_last[k]  = ($urandom_range(0, 9) < 4);
         end
         req_data = $urandom;
         if ($urandom_range(0, 299) == 0) uart_dead = ~uart_dead;
         if (fb > 0) fb--;
         else if ($urandom_range(0, 99) == 0) fb = 5;
         force_busy = (fb > 0);
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; uart_dead = 1'b0; force_busy = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
